pipe_ctrl: RTL and testbench

Central pipeline control for the 5-stage RISC-V core. Collects stall requests from fetch bus, decode hazard logic and multi-cycle execute units, plus branch/jump requests from execute. Drives hold/flush to PC, if_id and id_ex registers and the PC redirect. Defers a redirect that arrives while the fetch bus is busy. Keeps a stall-cycle counter and a fetch-bus timeout flag.

---
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central hold/flush/redirect control for the 5-stage core.
// A redirect raised while the fetch bus is busy is parked in PEND until the bus frees.
module pipe_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold_bus_i,
   input  logic             hold_id_i,
   input  logic             hold_ex_i,
   input  logic             jump_i,
   input  logic [31:0]      jump_addr_i,
   input  logic             tmo_clr_i,
   output logic             hold_pc_o,
   output logic             hold_if_id_o,
   output logic             hold_id_ex_o,
   output logic             flush_if_id_o,
   output logic             flush_id_ex_o,
   output logic             jump_o,
   output logic [31:0]      jump_addr_o,
   output logic             pend_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             bus_timeout_o
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PEND = 1'b1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]       state, state_nxt;
   logic [31:0]      pend_addr;
   logic [CNT_W-1:0] stall_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             bus_timeout;
   logic             take_jump;
   logic             hp, hi, he, fi, fe, jmp;
   logic [31:0]      jaddr;

   // execute never raises jump together with a mul/div hold; such a jump is dropped
   assign take_jump = (state == IDLE) && jump_i && !hold_ex_i;

   always_comb begin
      hp = 1'b0; hi = 1'b0; he = 1'b0;
      fi = 1'b0; fe = 1'b0;
      jmp = 1'b0; jaddr = 32'h0;
      state_nxt = state;
      if (hold_ex_i) begin
         hp = 1'b1; hi = 1'b1; he = 1'b1;
      end else if (hold_id_i) begin
         hp = 1'b1; hi = 1'b1; fe = 1'b1;
      end else if (hold_bus_i) begin
         hp = 1'b1; fi = 1'b1;
      end
      if (state == PEND) begin
         // if_id only ever holds wrong-path fetches here; id_ex keeps its normal holds
         fi = 1'b1; hi = 1'b0;
         if (hold_bus_i) begin
            hp = 1'b1;
         end else begin
            hp = 1'b0; jmp = 1'b1; jaddr = pend_addr;
            state_nxt = IDLE;
         end
      end else if (take_jump) begin
         fi = 1'b1; fe = 1'b1; hi = 1'b0; he = 1'b0;
         if (hold_bus_i) begin
            state_nxt = PEND;
         end else begin
            hp = 1'b0; jmp = 1'b1; jaddr = jump_addr_i;
         end
      end
   end

   assign hold_pc_o     = rst & hp;
   assign hold_if_id_o  = rst & hi;
   assign hold_id_ex_o  = rst & he;
   assign flush_if_id_o = rst & fi;
   assign flush_id_ex_o = rst & fe;
   assign jump_o        = rst & jmp;
   assign jump_addr_o   = rst ? jaddr : 32'h0;
   assign pend_o        = rst & (state == PEND);
   assign stall_cnt_o   = stall_cnt;
   assign bus_timeout_o = bus_timeout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pend_addr   <= 32'h0;
         stall_cnt   <= '0;
         tmo_cnt     <= '0;
         bus_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take_jump && hold_bus_i)
            pend_addr <= jump_addr_i;
         if (hp && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_ONE;
         if (!hold_bus_i)
            tmo_cnt <= '0;
         else if (tmo_cnt != TMO_MAX)
            tmo_cnt <= tmo_cnt + TMO_ONE;
         // clear beats a same-cycle set
         if (tmo_clr_i)
            bus_timeout <= 1'b0;
         else if (hold_bus_i && tmo_cnt >= TMO_MAX - TMO_ONE)
            bus_timeout <= 1'b1;
      end
   end

   a_no_stray_jump: assert property (@(posedge clk) disable iff (!rst)
      !(jump_i && (hold_ex_i || state == PEND)));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plan steps followed by constrained-random cycles, all checked against
// a rule-level reference model of the hold/flush/redirect behaviour.
module tb_pipe_ctrl;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             hold_bus_i = 1'b0, hold_id_i = 1'b0, hold_ex_i = 1'b0;
   logic             jump_i = 1'b0, tmo_clr_i = 1'b0;
   logic [31:0]      jump_addr_i = 32'h0;
   logic             hold_pc_o, hold_if_id_o, hold_id_ex_o;
   logic             flush_if_id_o, flush_id_ex_o, jump_o, pend_o, bus_timeout_o;
   logic [31:0]      jump_addr_o;
   logic [CNT_W-1:0] stall_cnt_o;

   pipe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .hold_bus_i(hold_bus_i), .hold_id_i(hold_id_i), .hold_ex_i(hold_ex_i),
      .jump_i(jump_i), .jump_addr_i(jump_addr_i), .tmo_clr_i(tmo_clr_i),
      .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
      .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
      .jump_o(jump_o), .jump_addr_o(jump_addr_o), .pend_o(pend_o),
      .stall_cnt_o(stall_cnt_o), .bus_timeout_o(bus_timeout_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state: outstanding redirect, counters, sticky flag
   bit          m_pend = 1'b0, n_pend;
   logic [31:0] m_paddr = 32'h0, n_paddr;
   int          m_stall = 0, n_stall;
   int          m_run = 0, n_run;
   bit          m_flag = 1'b0, n_flag;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit redirect, jump_ok, e_fi, e_fe, e_hi, e_he, e_hp;
      logic [31:0] target;
      if (!rst) begin
         m_pend = 0; m_paddr = 0; m_stall = 0; m_run = 0; m_flag = 0;
      end
      jump_ok  = !m_pend && jump_i && !hold_ex_i;
      redirect = (m_pend && !hold_bus_i) || (jump_ok && !hold_bus_i);
      target   = m_pend ? m_paddr : jump_addr_i;
      e_fi = m_pend || jump_ok || (hold_bus_i && !hold_ex_i && !hold_id_i);
      e_fe = jump_ok || (hold_id_i && !hold_ex_i);
      e_he = hold_ex_i;
      e_hi = (hold_ex_i || hold_id_i) && !e_fi;
      e_hp = !redirect && (hold_ex_i || hold_id_i || hold_bus_i || m_pend);
      if (!rst) begin
         redirect = 0; e_fi = 0; e_fe = 0; e_he = 0; e_hi = 0; e_hp = 0;
      end
      chk("hold_pc",     32'(hold_pc_o),     32'(e_hp));
      chk("hold_if_id",  32'(hold_if_id_o),  32'(e_hi));
      chk("hold_id_ex",  32'(hold_id_ex_o),  32'(e_he));
      chk("flush_if_id", 32'(flush_if_id_o), 32'(e_fi));
      chk("flush_id_ex", 32'(flush_id_ex_o), 32'(e_fe));
      chk("jump",        32'(jump_o),        32'(redirect));
      chk("jump_addr",   jump_addr_o,        redirect ? target : 32'h0);
      chk("pend",        32'(pend_o),        32'(m_pend && rst));
      chk("stall_cnt",   32'(stall_cnt_o),   32'(m_stall));
      chk("bus_timeout", 32'(bus_timeout_o), 32'(m_flag));
      if (!rst) begin
         n_pend = 0; n_paddr = 0; n_stall = 0; n_run = 0; n_flag = 0;
      end else begin
         n_pend  = m_pend ? hold_bus_i : (jump_ok && hold_bus_i);
         n_paddr = (!m_pend && jump_ok && hold_bus_i) ? jump_addr_i : m_paddr;
         n_stall = (e_hp && m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
         n_run   = hold_bus_i ? ((m_run < TIMEOUT) ? m_run + 1 : TIMEOUT) : 0;
         n_flag  = tmo_clr_i ? 1'b0 : (m_flag || (hold_bus_i && m_run + 1 >= TIMEOUT));
      end
   endtask

   task automatic tick();
      #1 check_all();
      @(posedge clk);
      m_pend = n_pend; m_paddr = n_paddr; m_stall = n_stall; m_run = n_run; m_flag = n_flag;
      @(negedge clk);
   endtask

   task automatic set_in(input bit bus, input bit id, input bit ex, input bit jmp,
                         input logic [31:0] addr, input bit clr);
      hold_bus_i = bus; hold_id_i = id; hold_ex_i = ex;
      jump_i = jmp; jump_addr_i = addr; tmo_clr_i = clr;
   endtask

   initial begin
      // reset with every request high
      set_in(1, 1, 1, 1, 32'hdeadbeef, 0);
      @(negedge clk);
      tick(); tick();
      chk("rst_stall", 32'(stall_cnt_o), 32'h0);
      // release: all holds, ex has priority
      jump_i = 0; rst = 1;
      tick(); tick(); tick();
      chk("prio_stall3", 32'(stall_cnt_o), 32'd3);
      set_in(1, 1, 0, 0, 0, 0);
      #1 chk("drop_ex_flush_id_ex", 32'(flush_id_ex_o), 32'h1);
      chk("drop_ex_hold_id_ex", 32'(hold_id_ex_o), 32'h0);
      tick();
      set_in(0, 0, 0, 0, 0, 1);
      tick();
      // direct jump
      set_in(0, 0, 0, 1, 32'h80000100, 0);
      #1 chk("direct_jump", 32'(jump_o), 32'h1);
      chk("direct_addr", jump_addr_o, 32'h80000100);
      tick();
      chk("direct_no_pend", 32'(pend_o), 32'h0);
      // deferred jump
      set_in(1, 0, 0, 1, 32'h00001234, 0);
      #1 chk("defer_no_jump", 32'(jump_o), 32'h0);
      tick();
      jump_i = 0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("defer_pend", 32'(pend_o), 32'h1);
         chk("defer_flush", 32'(flush_if_id_o), 32'h1);
         tick();
      end
      hold_bus_i = 0;
      #1 chk("defer_jump", 32'(jump_o), 32'h1);
      chk("defer_addr", jump_addr_o, 32'h00001234);
      tick();
      chk("defer_done", 32'(pend_o), 32'h0);
      set_in(0, 0, 0, 0, 0, 1);
      tick();
      // timeout
      set_in(1, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      hold_bus_i = 0;
      tick();
      chk("tmo_short", 32'(bus_timeout_o), 32'h0);
      hold_bus_i = 1;
      tick(); tick(); tick();
      chk("tmo_not_yet", 32'(bus_timeout_o), 32'h0);
      tick();
      chk("tmo_set", 32'(bus_timeout_o), 32'h1);
      tick();
      hold_bus_i = 0;
      tick(); tick();
      chk("tmo_sticky", 32'(bus_timeout_o), 32'h1);
      tmo_clr_i = 1;
      tick();
      tmo_clr_i = 0;
      chk("tmo_cleared", 32'(bus_timeout_o), 32'h0);
      // saturation
      set_in(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      chk("stall_sat", 32'(stall_cnt_o), 32'd15);
      // reset while a redirect is pending
      set_in(1, 0, 0, 1, 32'hcafe0000, 0);
      tick();
      jump_i = 0;
      tick();
      chk("pend_before_rst", 32'(pend_o), 32'h1);
      rst = 0;
      #1 chk("rst_pend", 32'(pend_o), 32'h0);
      tick();
      rst = 1; hold_bus_i = 0;
      #1 chk("rst_no_jump", 32'(jump_o), 32'h0);
      tick();
      // constrained random: no jump alongside ex hold or while pending
      for (int i = 0; i < 400; i++) begin
         hold_bus_i  = ($urandom_range(0, 9) < 4);
         hold_id_i   = ($urandom_range(0, 9) < 2);
         hold_ex_i   = ($urandom_range(0, 9) < 2);
         jump_addr_i = $urandom;
         jump_i      = !m_pend && !hold_ex_i && ($urandom_range(0, 3) == 0);
         tmo_clr_i   = ($urandom_range(0, 9) == 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
